// File: rtl/sram_pkg.sv
// Shared types for the banked SRAM controller: FSM states, read-pipe entry, bank-select width.
package sram_pkg;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_SCRUB,
    ST_RUN
  } state_e;

  // Bank field is sized for the largest supported bank count; users slice the low bits.
  localparam int MAX_BANK_SEL_W = 8;

  typedef struct packed {
    logic                      valid;
    logic [MAX_BANK_SEL_W-1:0] bank;
    logic                      err;
  } rd_pipe_t;

  function automatic int bank_sel_w(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

endpackage

// File: rtl/sram.sv
// Behavioural model of the sram macro: port 0 read/write with byte mask, read data READ_LATENCY
// cycles after the access and held between reads; port 1 is a registered read-only port.
module sram #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 13,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk0,
  input  logic                    csb0,
  input  logic                    web0,
  input  logic [DATA_WIDTH/8-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]   addr0,
  input  logic [DATA_WIDTH-1:0]   din0,
  output logic [DATA_WIDTH-1:0]   dout0,
  input  logic                    clk1,
  input  logic                    csb1,
  input  logic [ADDR_WIDTH-1:0]   addr1,
  output logic [DATA_WIDTH-1:0]   dout1
);

  localparam int NBYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem  [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_q [READ_LATENCY];

  always_ff @(posedge clk0) begin
    if (!csb0 && web0) rd_q[0] <= mem[addr0];
    for (int i = 1; i < READ_LATENCY; i++) rd_q[i] <= rd_q[i-1];
    if (!csb0 && !web0)
      for (int b = 0; b < NBYTES; b++)
        if (wmask0[b]) mem[addr0][8*b +: 8] <= din0[8*b +: 8];
  end

  assign dout0 = rd_q[READ_LATENCY-1];

  always_ff @(posedge clk1) begin
    if (!csb1) dout1 <= mem[addr1];
  end

endmodule

// File: rtl/sram_rd_pipe.sv
// Fixed-depth shift register carrying {valid, bank, err} alongside the macro read latency.
// Latency DEPTH cycles, no backpressure; asynchronous reset drops everything in flight.
module sram_rd_pipe
  import sram_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  rd_pipe_t head,
  output rd_pipe_t tail
);

  rd_pipe_t stage_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= head;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tail = stage_q[DEPTH-1];

endmodule

// File: rtl/sram_banked_ctrl.sv
// N-bank SRAM controller: one request per cycle, reads return after READ_LATENCY cycles,
// ready_o low during reset and the optional post-reset zero scrub; requester holds until accepted.
module sram_banked_ctrl
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int BANK_AW      = 13,
  parameter int NUM_BANKS    = 2,
  parameter int ADDR_WIDTH   = 28,
  parameter int READ_LATENCY = 1,
  parameter int ZERO_INIT    = 0,
  parameter     IFILE_BASE   = ""
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    csb_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wmask_i,
  output logic                    ready_o,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o
);

  localparam int BANK_SEL_W = bank_sel_w(NUM_BANKS);
  localparam int LOG2_NB    = $clog2(NUM_BANKS);
  localparam int HI_LSB     = BANK_AW + LOG2_NB;
  localparam int NBYTES     = DATA_WIDTH / 8;
  // Hex preload is part of the macro's own init flow; the file prefix is only carried here.
  localparam bit unused_ifile_base = (IFILE_BASE != "");

  state_e               state_q, state_d;
  logic [BANK_AW-1:0]   scrub_cnt_q, scrub_cnt_d;
  logic                 scrub_en;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_RESET;
      scrub_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      scrub_cnt_q <= scrub_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    scrub_cnt_d = scrub_cnt_q;
    scrub_en    = 1'b0;
    ready_o     = 1'b0;
    case (state_q)
      ST_RESET: state_d = (ZERO_INIT != 0) ? ST_SCRUB : ST_RUN;
      ST_SCRUB: begin
        scrub_en    = 1'b1;
        scrub_cnt_d = scrub_cnt_q + 1'b1;
        if (&scrub_cnt_q) state_d = ST_RUN;
      end
      ST_RUN:   ready_o = 1'b1;
      default:  state_d = ST_RESET;
    endcase
  end

  logic                  accept;
  logic                  oor;
  logic [BANK_SEL_W-1:0] bank_idx;

  assign accept = ~csb_i & ready_o;

  if (NUM_BANKS > 1) begin : g_bank_dec
    assign bank_idx = addr_i[BANK_AW +: LOG2_NB];
  end else begin : g_one_bank
    assign bank_idx = '0;
  end

  if (ADDR_WIDTH > HI_LSB) begin : g_oor
    assign oor = |addr_i[ADDR_WIDTH-1:HI_LSB];
  end else begin : g_no_oor
    assign oor = 1'b0;
  end

  // Scrub drives the shared macro inputs for every bank at once.
  logic                  mem_web;
  logic [BANK_AW-1:0]    mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [NBYTES-1:0]     mem_wmask;

  assign mem_web   = scrub_en ? 1'b0        : we_i;
  assign mem_addr  = scrub_en ? scrub_cnt_q : addr_i[BANK_AW-1:0];
  assign mem_din   = scrub_en ? '0          : wdata_i;
  assign mem_wmask = scrub_en ? '1          : wmask_i;

  logic [DATA_WIDTH-1:0] bank_dout    [NUM_BANKS];
  logic [DATA_WIDTH-1:0] unused_dout1 [NUM_BANKS];

  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
    logic bank_csb;
    assign bank_csb = ~(scrub_en | (accept & ~oor & (bank_idx == BANK_SEL_W'(k))));

    sram #(
      .DATA_WIDTH  (DATA_WIDTH),
      .ADDR_WIDTH  (BANK_AW),
      .READ_LATENCY(READ_LATENCY)
    ) u_sram (
      .clk0  (clk_i),
      .csb0  (bank_csb),
      .web0  (mem_web),
      .wmask0(mem_wmask),
      .addr0 (mem_addr),
      .din0  (mem_din),
      .dout0 (bank_dout[k]),
      .clk1  (clk_i),
      .csb1  (1'b1),
      .addr1 ('0),
      .dout1 (unused_dout1[k])
    );
  end

  rd_pipe_t pipe_in, pipe_out;

  always_comb begin
    pipe_in       = '0;
    pipe_in.valid = accept & we_i;
    pipe_in.bank  = MAX_BANK_SEL_W'(bank_idx);
    pipe_in.err   = oor;
  end

  sram_rd_pipe #(.DEPTH(READ_LATENCY)) u_rd_pipe (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .head (pipe_in),
    .tail (pipe_out)
  );

  logic [BANK_SEL_W-1:0] out_bank;
  logic                  unused_bank_hi;
  logic [DATA_WIDTH-1:0] rd_word, rdata_q;
  logic                  wr_err_q;

  assign out_bank       = pipe_out.bank[BANK_SEL_W-1:0];
  assign unused_bank_hi = ^pipe_out.bank;
  assign rd_word        = pipe_out.err ? '0 : bank_dout[out_bank];

  assign rvalid_o = pipe_out.valid;
  assign rdata_o  = pipe_out.valid ? rd_word : rdata_q;
  assign err_o    = (pipe_out.valid & pipe_out.err) | wr_err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q  <= '0;
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= accept & ~we_i & oor;
      if (pipe_out.valid) rdata_q <= rd_word;
    end
  end

endmodule

// File: tb/tb_sram_banked_ctrl.sv
// Directed bench: 2 banks x 16 words, 3-cycle reads, zero scrub; read returns checked by a scoreboard.
module tb_sram_banked_ctrl;

  localparam int L = 3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        csb_i;
  logic        we_i;
  logic [7:0]  addr_i;
  logic [31:0] wdata_i;
  logic [3:0]  wmask_i;
  logic        ready_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  always #5 clk_i = ~clk_i;

  sram_banked_ctrl #(
    .DATA_WIDTH  (32),
    .BANK_AW     (4),
    .NUM_BANKS   (2),
    .ADDR_WIDTH  (8),
    .READ_LATENCY(L),
    .ZERO_INIT   (1),
    .IFILE_BASE  ("")
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .csb_i   (csb_i),
    .we_i    (we_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .wmask_i (wmask_i),
    .ready_o (ready_o),
    .rvalid_o(rvalid_o),
    .rdata_o (rdata_o),
    .err_o   (err_o)
  );

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   rv_seen  = 0;
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (rvalid_o === 1'b1) begin
      exp_t e;
      rv_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rd_cycle", cyc, e.cyc);
        chk("rd_data", rdata_o, e.data);
        chk("rd_err", {31'b0, err_o}, {31'b0, e.err});
      end
    end
  end

  // Called just after a negedge; leaves the request up for exactly one accept edge.
  task automatic drive(input bit wr, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] m, input logic [31:0] exp_d, input bit exp_err);
    csb_i   = 1'b0;
    we_i    = wr ? 1'b0 : 1'b1;
    addr_i  = a;
    wdata_i = d;
    wmask_i = m;
    if (!wr) exp_q.push_back('{cyc: cyc + L, data: exp_d, err: exp_err});
    @(negedge clk_i);
    if (wr) chk("wr_err", {31'b0, err_o}, {31'b0, exp_err});
  endtask

  task automatic idle();
    csb_i = 1'b1;
    we_i  = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic drain();
    csb_i = 1'b1;
    we_i  = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk_i);
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic count_scrub(input string tag);
    int n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (ready_o) break;
      n++;
    end
    chk(tag, n, 16);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int rv_base;
    rst_i   = 1'b1;
    csb_i   = 1'b1;
    we_i    = 1'b1;
    addr_i  = '0;
    wdata_i = '0;
    wmask_i = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_ready", {31'b0, ready_o}, 32'd0);
    chk("rst_rvalid", {31'b0, rvalid_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_err", {31'b0, err_o}, 32'd0);

    rst_i = 1'b0;
    count_scrub("scrub_len");

    // Scrubbed contents in both banks
    drive(0, 8'h05, '0, '0, 32'h0000_0000, 0);
    drive(0, 8'h15, '0, '0, 32'h0000_0000, 0);
    drain();

    // Byte-masked overwrite, then read straight after the write
    drive(1, 8'h03, 32'hDEAD_BEEF, 4'b1111, '0, 0);
    drive(1, 8'h03, 32'h0000_00AA, 4'b0001, '0, 0);
    drive(0, 8'h03, '0, '0, 32'hDEAD_BEAA, 0);
    drain();

    // One word per bank, consecutive reads
    drive(1, 8'h00, 32'h1111_1111, 4'hF, '0, 0);
    drive(1, 8'h10, 32'h2222_2222, 4'hF, '0, 0);
    drive(0, 8'h00, '0, '0, 32'h1111_1111, 0);
    drive(0, 8'h10, '0, '0, 32'h2222_2222, 0);
    drain();

    // Four back-to-back reads crossing banks
    drive(1, 8'h01, 32'hA1A1_A1A1, 4'hF, '0, 0);
    drive(1, 8'h11, 32'hB2B2_B2B2, 4'hF, '0, 0);
    drive(1, 8'h02, 32'hC3C3_C3C3, 4'hF, '0, 0);
    drive(0, 8'h01, '0, '0, 32'hA1A1_A1A1, 0);
    drive(0, 8'h11, '0, '0, 32'hB2B2_B2B2, 0);
    drive(0, 8'h02, '0, '0, 32'hC3C3_C3C3, 0);
    drive(0, 8'h03, '0, '0, 32'hDEAD_BEAA, 0);
    drain();

    // Out-of-range accesses and a zero-mask write
    drive(0, 8'h20, '0, '0, 32'h0000_0000, 1);
    drive(0, 8'hE3, '0, '0, 32'h0000_0000, 1);
    drain();
    drive(1, 8'h20, 32'h5555_5555, 4'hF, '0, 1);
    idle();
    chk("wr_err_clear", {31'b0, err_o}, 32'd0);
    drive(1, 8'h03, 32'hFFFF_FFFF, 4'b0000, '0, 0);
    drive(0, 8'h00, '0, '0, 32'h1111_1111, 0);
    drive(0, 8'h10, '0, '0, 32'h2222_2222, 0);
    drive(0, 8'h03, '0, '0, 32'hDEAD_BEAA, 0);
    drain();
    repeat (3) idle();
    chk("rdata_hold", rdata_o, 32'hDEAD_BEAA);
    chk("rvalid_idle", {31'b0, rvalid_o}, 32'd0);

    // Reset at scrub row 7 restarts the full scrub
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (8) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("midscrub_ready", {31'b0, ready_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    count_scrub("scrub_restart_len");
    drive(0, 8'h03, '0, '0, 32'h0000_0000, 0);
    drive(0, 8'h1F, '0, '0, 32'h0000_0000, 0);
    drain();

    // Reset with two reads in flight
    drive(1, 8'h07, 32'h7777_7777, 4'hF, '0, 0);
    csb_i  = 1'b0;
    we_i   = 1'b1;
    addr_i = 8'h07;
    @(negedge clk_i);
    addr_i = 8'h17;
    @(negedge clk_i);
    csb_i   = 1'b1;
    rv_base = rv_seen;
    rst_i   = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    count_scrub("scrub_after_inflight");
    repeat (5) @(negedge clk_i);
    chk("no_rvalid_after_rst", rv_seen - rv_base, 0);
    drive(0, 8'h07, '0, '0, 32'h0000_0000, 0);
    drain();
    chk("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
